// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage: FSM states,
// memory-op bit positions, flag positions and branch condition codes.
package mem_stage_pkg;

    localparam int unsigned WB_ADDR_W = 5;
    localparam int unsigned MEM_OP_W  = 2;
    localparam int unsigned FLAGS_W   = 3;
    localparam int unsigned BR_OP_W   = 3;

    // iMemOp = {access, write}
    localparam int unsigned MEM_OP_ACCESS = 1;
    localparam int unsigned MEM_OP_WRITE  = 0;

    // data memory op = {valid, rw}
    localparam int unsigned DMEM_OP_VALID = 1;
    localparam int unsigned DMEM_OP_RW    = 0;

    // flags = {Zero, Negative, Overflow}
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    localparam logic [BR_OP_W-1:0] BR_ALWAYS = 3'b000;
    localparam logic [BR_OP_W-1:0] BR_EQ     = 3'b001;
    localparam logic [BR_OP_W-1:0] BR_NE     = 3'b010;
    localparam logic [BR_OP_W-1:0] BR_LT     = 3'b011;
    localparam logic [BR_OP_W-1:0] BR_GT     = 3'b100;
    localparam logic [BR_OP_W-1:0] BR_LE     = 3'b101;
    localparam logic [BR_OP_W-1:0] BR_GE     = 3'b110;
    localparam logic [BR_OP_W-1:0] BR_VS     = 3'b111;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic                 mem_to_reg;
        logic                 write_en;
        logic [WB_ADDR_W-1:0] write_addr;
    } wb_ctrl_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution: taken = branch_cmd & condition(branch_op, flags).
module branch_cond_eval
    import mem_stage_pkg::*;
(
    input  logic               branch_cmd,
    input  logic [BR_OP_W-1:0] branch_op,
    input  logic [FLAGS_W-1:0] flags,
    output logic               taken_c
);

    logic z;
    logic lt;
    logic cond;

    assign z  = flags[FLAG_Z];
    assign lt = flags[FLAG_N] ^ flags[FLAG_V];

    always_comb begin
        cond = 1'b0;
        unique case (branch_op)
            BR_ALWAYS: cond = 1'b1;
            BR_EQ:     cond = z;
            BR_NE:     cond = !z;
            BR_LT:     cond = lt;
            BR_GT:     cond = !lt && !z;
            BR_LE:     cond = lt || z;
            BR_GE:     cond = !lt;
            BR_VS:     cond = flags[FLAG_V];
            default:   cond = 1'b0;
        endcase
    end

    assign taken_c = branch_cmd && cond;

endmodule

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: issues loads/stores, builds in-order write-back entries
// and flags branch mispredicts. Optional access timeout via MEMSTAGE_TIMEOUT_EN.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
`ifdef MEMSTAGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 256
`endif
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready_c,
    input  logic [DATA_W-1:0]   exu_result,
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [DATA_W-1:0]   mem_data,
    input  wb_ctrl_t            ex_wb_ctrl,
    input  logic                branch_cmd,
    input  logic [BR_OP_W-1:0]  branch_op,
    input  logic                branch_predict,
    input  logic [DATA_W-1:0]   branch_addr,
    input  logic [DATA_W-1:0]   next_pc,
    input  logic [FLAGS_W-1:0]  flags,
    output logic [MEM_OP_W-1:0] data_mem_op,
    output logic [DATA_W-1:0]   data_mem_addr,
    output logic [DATA_W-1:0]   data_mem_wdata,
    input  logic                data_mem_ready,
    input  logic [DATA_W-1:0]   data_mem_rdata,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [DATA_W-1:0]   wb_data,
    output wb_ctrl_t            wb_ctrl,
    output logic                branch_miss_cmd,
`ifdef MEMSTAGE_TIMEOUT_EN
    output logic                mem_timeout,
`endif
    output logic [DATA_W-1:0]   branch_miss_addr
);

    state_t state_q;
    state_t state_d;
    logic   accept_c;
    logic   mem_done_c;
    logic   mem_abort_c;
    logic   taken_c;

    branch_cond_eval u_branch_cond (
        .branch_cmd (branch_cmd),
        .branch_op  (branch_op),
        .flags      (flags),
        .taken_c    (taken_c)
    );

`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_hit_c;

    // Hit on the last permitted ACCESS cycle; a same-edge ready still wins.
    assign tmo_hit_c = (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !data_mem_ready && !tmo_hit_c) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_timeout <= 1'b0;
        end else if (mem_abort_c) begin
            mem_timeout <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and access-completion decode.
    always_comb begin
        state_d     = state_q;
        ex_ready_c  = 1'b0;
        accept_c    = 1'b0;
        mem_done_c  = 1'b0;
        mem_abort_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                ex_ready_c = !wb_valid || wb_ready;
                accept_c   = ex_valid && ex_ready_c;
                if (accept_c && mem_op[MEM_OP_ACCESS]) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (data_mem_ready) begin
                    mem_done_c = 1'b1;
                    state_d    = IDLE;
                end
`ifdef MEMSTAGE_TIMEOUT_EN
                else if (tmo_hit_c) begin
                    mem_abort_c = 1'b1;
                    state_d     = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Write-back entry and data memory request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid       <= 1'b0;
            wb_data        <= '0;
            wb_ctrl        <= '0;
            data_mem_op    <= '0;
            data_mem_addr  <= '0;
            data_mem_wdata <= '0;
        end else if (accept_c) begin
            wb_ctrl <= ex_wb_ctrl;
            if (mem_op[MEM_OP_ACCESS]) begin
                wb_valid                   <= 1'b0;
                data_mem_op[DMEM_OP_VALID] <= 1'b1;
                data_mem_op[DMEM_OP_RW]    <= mem_op[MEM_OP_WRITE];
                data_mem_addr              <= exu_result;
                data_mem_wdata             <= mem_data;
            end else begin
                wb_valid <= 1'b1;
                wb_data  <= exu_result;
            end
        end else if (mem_done_c) begin
            wb_valid    <= 1'b1;
            wb_data     <= wb_ctrl.mem_to_reg ? data_mem_rdata : data_mem_addr;
            data_mem_op <= '0;
        end else if (mem_abort_c) begin
            wb_valid         <= 1'b1;
            wb_data          <= '0;
            wb_ctrl.write_en <= 1'b0;
            data_mem_op      <= '0;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    // Mispredict pulse; redirect address held until the next accepted branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_miss_cmd  <= 1'b0;
            branch_miss_addr <= '0;
        end else begin
            branch_miss_cmd <= accept_c && (taken_c ^ branch_predict);
            if (accept_c && branch_cmd) begin
                branch_miss_addr <= branch_predict ? next_pc : branch_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe with a write-back scoreboard queue.
// Build with MEMSTAGE_TIMEOUT_EN to exercise the access timeout.
module tb_mem_stage_pipe;
    import mem_stage_pkg::*;

    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        wb_ctrl_t      ctrl;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ex_valid = 1'b0;
    logic            ex_ready_c;
    logic [DW-1:0]   exu_result = '0;
    logic [1:0]      mem_op = '0;
    logic [DW-1:0]   mem_data = '0;
    wb_ctrl_t        ex_wb_ctrl = '0;
    logic            branch_cmd = 1'b0;
    logic [2:0]      branch_op = '0;
    logic            branch_predict = 1'b0;
    logic [DW-1:0]   branch_addr = '0;
    logic [DW-1:0]   next_pc = '0;
    logic [2:0]      flags = '0;
    logic [1:0]      data_mem_op;
    logic [DW-1:0]   data_mem_addr;
    logic [DW-1:0]   data_mem_wdata;
    logic            data_mem_ready = 1'b0;
    logic [DW-1:0]   data_mem_rdata = '0;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [DW-1:0]   wb_data;
    wb_ctrl_t        wb_ctrl;
    logic            branch_miss_cmd;
    logic [DW-1:0]   branch_miss_addr;
`ifdef MEMSTAGE_TIMEOUT_EN
    logic            mem_timeout;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mem_stage_pipe #(
        .DATA_W (DW)
`ifdef MEMSTAGE_TIMEOUT_EN
      , .TIMEOUT_CYC (4)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_ready_c       (ex_ready_c),
        .exu_result       (exu_result),
        .mem_op           (mem_op),
        .mem_data         (mem_data),
        .ex_wb_ctrl       (ex_wb_ctrl),
        .branch_cmd       (branch_cmd),
        .branch_op        (branch_op),
        .branch_predict   (branch_predict),
        .branch_addr      (branch_addr),
        .next_pc          (next_pc),
        .flags            (flags),
        .data_mem_op      (data_mem_op),
        .data_mem_addr    (data_mem_addr),
        .data_mem_wdata   (data_mem_wdata),
        .data_mem_ready   (data_mem_ready),
        .data_mem_rdata   (data_mem_rdata),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_data          (wb_data),
        .wb_ctrl          (wb_ctrl),
        .branch_miss_cmd  (branch_miss_cmd),
`ifdef MEMSTAGE_TIMEOUT_EN
        .mem_timeout      (mem_timeout),
`endif
        .branch_miss_addr (branch_miss_addr)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond_model(input logic [2:0] code, input logic [2:0] f);
        logic z, n, v;
        z = f[2];
        n = f[1];
        v = f[0];
        case (code)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return n != v;
            3'd4:    return (n == v) && !z;
            3'd5:    return (n != v) || z;
            3'd6:    return n == v;
            default: return v;
        endcase
    endfunction

    function automatic wb_ctrl_t mk_ctrl(input logic m2r, input logic we, input logic [4:0] wa);
        wb_ctrl_t c;
        c.mem_to_reg = m2r;
        c.write_en   = we;
        c.write_addr = wa;
        return c;
    endfunction

    // Retirement monitor: an entry leaves when valid and ready meet at an edge.
    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", wb_data, e.data);
                chk("sb_ctrl", 32'(wb_ctrl), 32'(e.ctrl));
            end
        end
    end

    task automatic drive_op(input logic [DW-1:0] res, input logic [1:0] op,
                            input logic [DW-1:0] sdata, input wb_ctrl_t c);
        ex_valid   = 1'b1;
        exu_result = res;
        mem_op     = op;
        mem_data   = sdata;
        ex_wb_ctrl = c;
    endtask

    initial begin
        wb_ctrl_t c;
        logic     exp_taken;

        // Reset values while reset is held
        #12;
        chk("rst_dmem_op", 32'(data_mem_op), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_miss_cmd", 32'(branch_miss_cmd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_ctrl", 32'(wb_ctrl), 32'd0);
        chk("rst_miss_addr", branch_miss_addr, 32'd0);
        chk("rst_dmem_addr", data_mem_addr, 32'd0);
        chk("rst_dmem_wdata", data_mem_wdata, 32'd0);
`ifdef MEMSTAGE_TIMEOUT_EN
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ALU op, latency 1
        c = mk_ctrl(1'b0, 1'b1, 5'd5);
        wb_ready = 1'b1;
        drive_op(32'h1234, 2'b00, 32'h0, c);
        #1;
        chk("alu_ready", 32'(ex_ready_c), 32'd1);
        sb_q.push_back('{data: 32'h1234, ctrl: c});
        tick();
        ex_valid = 1'b0;
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_data", wb_data, 32'h1234);
        chk("alu_waddr", 32'(wb_ctrl.write_addr), 32'd5);
        tick();
        chk("alu_retired", 32'(wb_valid), 32'd0);

        // Load, memory ready on the third access cycle
        c = mk_ctrl(1'b1, 1'b1, 5'd7);
        drive_op(32'h40, 2'b10, 32'h0, c);
        sb_q.push_back('{data: 32'hDEADBEEF, ctrl: c});
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ld_dmem_op", 32'(data_mem_op), 32'h2);
            chk("ld_dmem_addr", data_mem_addr, 32'h40);
            chk("ld_ex_ready", 32'(ex_ready_c), 32'd0);
            chk("ld_wb_valid", 32'(wb_valid), 32'd0);
            if (i == 2) begin
                data_mem_ready = 1'b1;
                data_mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        data_mem_ready = 1'b0;
        chk("ld_done_op", 32'(data_mem_op), 32'd0);
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        tick();

        // Store, memory ready immediately; entry carries the address
        c = mk_ctrl(1'b0, 1'b0, 5'd0);
        drive_op(32'h80, 2'b11, 32'hCAFEF00D, c);
        sb_q.push_back('{data: 32'h80, ctrl: c});
        tick();
        ex_valid = 1'b0;
        chk("st_dmem_op", 32'(data_mem_op), 32'h3);
        chk("st_dmem_wdata", data_mem_wdata, 32'hCAFEF00D);
        data_mem_ready = 1'b1;
        tick();
        data_mem_ready = 1'b0;
        chk("st_wb_valid", 32'(wb_valid), 32'd1);
        chk("st_wb_data", wb_data, 32'h80);
        tick();

        // Branch EQ with Z set, predicted not taken
        c = mk_ctrl(1'b0, 1'b0, 5'd0);
        drive_op(32'h55, 2'b00, 32'h0, c);
        branch_cmd = 1'b1; branch_op = 3'b001; flags = 3'b100;
        branch_predict = 1'b0; branch_addr = 32'h100; next_pc = 32'h2000;
        sb_q.push_back('{data: 32'h55, ctrl: c});
        tick();
        ex_valid = 1'b0; branch_cmd = 1'b0;
        chk("br_miss_pulse", 32'(branch_miss_cmd), 32'd1);
        chk("br_miss_addr", branch_miss_addr, 32'h100);
        tick();
        chk("br_miss_end", 32'(branch_miss_cmd), 32'd0);
        chk("br_addr_held", branch_miss_addr, 32'h100);

        // Same branch predicted taken: no pulse
        drive_op(32'h56, 2'b00, 32'h0, c);
        branch_cmd = 1'b1; branch_predict = 1'b1;
        sb_q.push_back('{data: 32'h56, ctrl: c});
        tick();
        ex_valid = 1'b0; branch_cmd = 1'b0; branch_predict = 1'b0;
        chk("br_pred_nopulse", 32'(branch_miss_cmd), 32'd0);
        chk("br_pred_addr", branch_miss_addr, 32'h2000);
        tick();

        // Back-to-back sweep of every condition code
        for (int code = 0; code < 8; code++) begin
            for (int k = 0; k < 2; k++) begin
                c = mk_ctrl(1'b0, 1'b1, 5'(code));
                drive_op(32'h300 + 32'(code * 2 + k), 2'b00, 32'h0, c);
                branch_cmd     = 1'b1;
                branch_op      = 3'(code);
                flags          = 3'($urandom_range(0, 7));
                branch_predict = k[0];
                exp_taken      = cond_model(3'(code), flags);
                sb_q.push_back('{data: 32'h300 + 32'(code * 2 + k), ctrl: c});
                tick();
                chk("cc_miss", 32'(branch_miss_cmd), 32'(exp_taken ^ k[0]));
            end
        end
        ex_valid = 1'b0; branch_cmd = 1'b0; branch_predict = 1'b0;
        tick();

        // Write-back stall, then release together with a new accept
        wb_ready = 1'b0;
        c = mk_ctrl(1'b0, 1'b1, 5'd10);
        drive_op(32'hA1, 2'b00, 32'h0, c);
        #1;
        chk("bp_ready0", 32'(ex_ready_c), 32'd1);
        sb_q.push_back('{data: 32'hA1, ctrl: c});
        tick();
        c = mk_ctrl(1'b0, 1'b1, 5'd11);
        drive_op(32'hB2, 2'b00, 32'h0, c);
        #1;
        chk("bp_stall_ready", 32'(ex_ready_c), 32'd0);
        chk("bp_held_data", wb_data, 32'hA1);
        tick();
        chk("bp_held_valid", 32'(wb_valid), 32'd1);
        chk("bp_held_data2", wb_data, 32'hA1);
        wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(ex_ready_c), 32'd1);
        sb_q.push_back('{data: 32'hB2, ctrl: c});
        tick();
        ex_valid = 1'b0;
        chk("bp_nobubble_valid", 32'(wb_valid), 32'd1);
        chk("bp_nobubble_data", wb_data, 32'hB2);
        tick();
        chk("bp_drained", 32'(wb_valid), 32'd0);

`ifdef MEMSTAGE_TIMEOUT_EN
        // Memory never answers: abort after 4 access cycles
        c = mk_ctrl(1'b1, 1'b1, 5'd9);
        drive_op(32'h44, 2'b10, 32'h0, c);
        sb_q.push_back('{data: 32'h0, ctrl: mk_ctrl(1'b1, 1'b0, 5'd9)});
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_dmem_op", 32'(data_mem_op), 32'h2);
            tick();
        end
        chk("tmo_abort_op", 32'(data_mem_op), 32'd0);
        chk("tmo_flag", 32'(mem_timeout), 32'd1);
        chk("tmo_wb_valid", 32'(wb_valid), 32'd1);
        chk("tmo_we", 32'(wb_ctrl.write_en), 32'd0);
        chk("tmo_wb_data", wb_data, 32'd0);
        tick();
        chk("tmo_sticky", 32'(mem_timeout), 32'd1);
`else
        // Memory answers late: the access waits as long as needed
        c = mk_ctrl(1'b1, 1'b1, 5'd3);
        drive_op(32'h48, 2'b10, 32'h0, c);
        sb_q.push_back('{data: 32'h0BADF00D, ctrl: c});
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("wait_dmem_op", 32'(data_mem_op), 32'h2);
            tick();
        end
        data_mem_ready = 1'b1;
        data_mem_rdata = 32'h0BADF00D;
        tick();
        data_mem_ready = 1'b0;
        chk("wait_wb_data", wb_data, 32'h0BADF00D);
        tick();
`endif

        // Reset in the middle of an access aborts it at once
        c = mk_ctrl(1'b1, 1'b1, 5'd4);
        drive_op(32'h90, 2'b10, 32'h0, c);
        tick();
        ex_valid = 1'b0;
        chk("rstacc_op_before", 32'(data_mem_op), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstacc_op", 32'(data_mem_op), 32'd0);
        chk("rstacc_ready", 32'(ex_ready_c), 32'd1);
        chk("rstacc_wb_valid", 32'(wb_valid), 32'd0);
`ifdef MEMSTAGE_TIMEOUT_EN
        chk("rstacc_timeout", 32'(mem_timeout), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Recovery after reset
        c = mk_ctrl(1'b0, 1'b1, 5'd1);
        drive_op(32'h77, 2'b00, 32'h0, c);
        sb_q.push_back('{data: 32'h77, ctrl: c});
        tick();
        ex_valid = 1'b0;
        chk("post_rst_data", wb_data, 32'h77);
        tick();
        tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 DATA_W, 32: width of data, address and PC paths.
REQ-002 TIMEOUT_CYC, 256: maximum ACCESS cycles before abort; effective only with MEMSTAGE_TIMEOUT_EN.
REQ-003 iClk  in  1  single clock; all state changes on the rising edge.
REQ-004 iRst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 iExValid  in  1  execute stage presents an operation.
REQ-006 oExReady  out  1  stage accepts the operation this cycle.
REQ-007 iExuResult  in  DATA_W  ALU result; also the memory address.
REQ-008 iMemOp  in  2  {access, write}.
REQ-009 iMemData  in  DATA_W  store data.
REQ-010 iWbCtrl  in  7  {MemToReg, WriteEn, WriteAddr[4:0]}.
REQ-011 iBranchCmd  in  1  operation is a conditional branch.
REQ-012 iBranchOp  in  3  branch condition code.
REQ-013 iBranchPredict  in  1  fetch predicted taken.
REQ-014 iBranchAddr  in  DATA_W  branch target.
REQ-015 iNextPC  in  DATA_W  fall-through PC.
REQ-016 iFlags  in  3  {Zero, Negative, Overflow}.
REQ-017 oDataMemOp  out  2  {valid, rw} to data memory.
REQ-018 oDataMemAddr  out  DATA_W  data memory address.
REQ-019 oDataMemData  out  DATA_W  data memory write data.
REQ-020 iDataMemReady  in  1  data memory completes the access this cycle.
REQ-021 iDataMemData  in  DATA_W  load data, valid with iDataMemReady.
REQ-022 oWbValid  out  1  write-back entry valid.
REQ-023 iWbReady  in  1  write-back consumes the entry.
REQ-024 oWbData  out  DATA_W  load data if MemToReg, else ALU result.
REQ-025 oWbCtrl  out  7  registered iWbCtrl.
REQ-026 oBranchMissCmd  out  1  one-cycle mispredict pulse.
REQ-027 oBranchMissAddr  out  DATA_W  redirect PC: iNextPC if predicted taken, else iBranchAddr.
REQ-028 oMemTimeout  out  1  sticky timeout flag; port exists only with MEMSTAGE_TIMEOUT_EN.

Function
REQ-029 The FSM SHALL have two states, IDLE and ACCESS; oExReady = IDLE and (!oWbValid or iWbReady).
REQ-030 On accept of a non-memory operation, the stage SHALL present oWbValid/oWbData/oWbCtrl on the next edge (latency 1) and hold them until iWbReady.
REQ-031 On accept with iMemOp.access, the stage SHALL go to ACCESS, clear oWbValid, register the address, data and rw, and assert oDataMemOp.valid from the next cycle, holding all three stable until iDataMemReady.
REQ-032 In ACCESS with iDataMemReady, the stage SHALL load the write-back entry (oWbData = iDataMemData if MemToReg, else the registered result), drop oDataMemOp.valid and return to IDLE on the same edge.
REQ-033 Stores SHALL also produce a write-back entry so retirement stays in order.
REQ-034 Condition codes: 000 always, 001 Z, 010 !Z, 011 N^V, 100 !(N^V)&!Z, 101 (N^V)|Z, 110 !(N^V), 111 V.
REQ-035 Taken = iBranchCmd & condition; on accept, oBranchMissCmd SHALL pulse for exactly one cycle next edge when taken ^ iBranchPredict, with oBranchMissAddr registered and held until the next accepted branch.
REQ-036 Simultaneous iWbReady and accept SHALL replace the entry with no bubble.

Reset
REQ-037 When iRst_n is low, the stage SHALL go to IDLE immediately, and oDataMemOp, oWbValid, oBranchMissCmd, oMemTimeout and the timeout counter SHALL be 0; oWbData, oWbCtrl, oBranchMissAddr, oDataMemAddr and oDataMemData SHALL be 0. A reset during ACCESS SHALL abort the access.

Configuration
REQ-038 With MEMSTAGE_TIMEOUT_EN, ACCESS cycles SHALL be counted; if TIMEOUT_CYC cycles pass without iDataMemReady, the stage SHALL abort to IDLE and emit an entry with data 0 and WriteEn forced 0. oMemTimeout SHALL set and stay set until reset.
REQ-039 Without MEMSTAGE_TIMEOUT_EN, ACCESS SHALL wait indefinitely, and the counter and port SHALL be absent.

Structure
REQ-040 Package mem_stage_pkg SHALL hold the FSM state enum, the iMemOp/oDataMemOp bit positions and the branch condition-code constants.
REQ-041 A combinational sub-module branch_cond_eval SHALL compute taken from iBranchOp, iBranchCmd and iFlags.

Verification
REQ-042 ALU operation 0x1234, WriteAddr 5, iWbReady=1 -> oWbValid next cycle, oWbData=0x1234, oWbCtrl WriteAddr=5.
REQ-043 Load at 0x40, memory ready after 3 cycles with 0xDEADBEEF -> address stable 3 cycles, oExReady=0 throughout, oWbData=0xDEADBEEF.
REQ-044 Branch op 001, Z=1, predict 0, target 0x100 -> oBranchMissCmd one-cycle pulse, oBranchMissAddr=0x100; with predict 1 -> no pulse.
REQ-045 iWbReady held 0 with an entry valid -> oExReady=0 and the entry held; release together with a new accept -> back-to-back entries with no bubble.
REQ-046 With MEMSTAGE_TIMEOUT_EN and TIMEOUT_CYC=4, memory never ready -> abort after 4 cycles, oMemTimeout=1, entry WriteEn=0; iRst_n pulsed mid-ACCESS -> oDataMemOp=0 immediately.
